// File: rtl/hex_entry_capture_pkg.sv
// Shared constants for the hex entry path: debounce timing and raw key level encoding.
package hex_entry_capture_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CYCLES_SIM     = 4;
    localparam int CNT_W_DEFAULT           = 20;

    // Board push-buttons pull low when pressed.
    typedef enum logic {
        KEY_PRESSED  = 1'b0,
        KEY_RELEASED = 1'b1
    } key_level_e;

endpackage

// File: rtl/hex_entry_capture_key_debounce.sv
// Per-key conditioning: two-flop synchronizer, stability counter and a registered press strobe.
module key_debounce
    import hex_entry_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    key_level_e       state;
    key_level_e       state_prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= KEY_RELEASED;
            sync_2     <= KEY_RELEASED;
            state      <= KEY_RELEASED;
            state_prev <= KEY_RELEASED;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;

            // Any sample matching the accepted level restarts qualification.
            if (sync_2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= key_level_e'(sync_2);
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            state_prev <= state;
            press      <= (state == KEY_PRESSED) && (state_prev == KEY_RELEASED);
        end
    end

endmodule

// File: rtl/hex_entry_capture.sv
// Operator hex word entry: nibble shift register driven by debounced keys, handed to the CPU via valid/ack.
module hex_entry_capture
    import hex_entry_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_nibble,
    input  logic        key_shift_n,
    input  logic        key_commit_n,
    input  logic        key_clear_n,
    output logic [31:0] entry,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ack,
    output logic        overrun
);

    logic shift_p;
    logic commit_p;
    logic clear_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_shift (
        .clk   (clk),
        .reset (reset),
        .key_n (key_shift_n),
        .press (shift_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_commit (
        .clk   (clk),
        .reset (reset),
        .key_n (key_commit_n),
        .press (commit_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .press (clear_p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            entry      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (clear_p) begin
                entry <= '0;
            end else if (shift_p) begin
                entry <= {entry[27:0], sw_nibble};
            end

            // Commit captures the pre-update entry; a same-cycle ack consumes the old word only.
            if (commit_p) begin
                word_out   <= entry;
                word_valid <= 1'b1;
            end else if (word_ack) begin
                word_valid <= 1'b0;
            end

            if (clear_p) begin
                overrun <= 1'b0;
            end else if (commit_p && word_valid && !word_ack) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_entry_capture.sv
// Directed plus randomized bench for hex_entry_capture against an in-bench behavioural model.
module tb_hex_entry_capture;
    import hex_entry_capture_pkg::*;

    localparam int DB = DEBOUNCE_CYCLES_SIM;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw_nibble;
    logic        key_shift_n;
    logic        key_commit_n;
    logic        key_clear_n;
    logic [31:0] entry;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ack;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    hex_entry_capture #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_nibble    (sw_nibble),
        .key_shift_n  (key_shift_n),
        .key_commit_n (key_commit_n),
        .key_clear_n  (key_clear_n),
        .entry        (entry),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ack     (word_ack),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A key press is accepted once the (2-cycle delayed) key level has differed from the
    // accepted level for DB consecutive clocks; the action lands two clocks later.
    logic [31:0] m_entry, m_wout, m_old;
    logic        m_wv, m_ov;
    bit          started = 0;
    logic [1:0]  dly [3];
    logic        st_m [3];
    int          run_m [3];
    int          fire [3];
    logic [2:0]  m_raw, m_due;
    logic        m_lvl;

    always @(posedge clk) begin
        m_raw = {key_clear_n, key_commit_n, key_shift_n};
        if (reset) begin
            started = 1;
            m_entry = '0; m_wout = '0; m_wv = 1'b0; m_ov = 1'b0;
            for (int k = 0; k < 3; k++) begin
                dly[k] = 2'b11; st_m[k] = 1'b1; run_m[k] = 0; fire[k] = 0;
            end
        end else if (started) begin
            for (int k = 0; k < 3; k++) begin
                m_due[k] = 1'b0;
                if (fire[k] > 0) begin
                    fire[k]--;
                    m_due[k] = (fire[k] == 0);
                end
                m_lvl  = dly[k][1];
                dly[k] = {dly[k][0], m_raw[k]};
                if (m_lvl != st_m[k]) begin
                    run_m[k]++;
                    if (run_m[k] == DB) begin
                        st_m[k]  = m_lvl;
                        run_m[k] = 0;
                        if (m_lvl == 1'b0) fire[k] = 2;
                    end
                end else begin
                    run_m[k] = 0;
                end
            end
            m_old = m_entry;
            if (m_due[2]) m_entry = '0;
            else if (m_due[0]) m_entry = {m_entry[27:0], sw_nibble};
            if (m_due[1]) begin
                m_wout = m_old;
                if (m_wv && !word_ack) m_ov = 1'b1;
                m_wv = 1'b1;
            end else if (word_ack && m_wv) begin
                m_wv = 1'b0;
            end
            if (m_due[2]) m_ov = 1'b0;
        end
    end

    // ---------------- continuous compare ----------------
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (entry !== m_entry || word_out !== m_wout || word_valid !== m_wv || overrun !== m_ov) begin
                failures++;
                $display("FAIL cmp t=%0t act entry=%h word_out=%h valid=%b ovr=%b exp entry=%h word_out=%h valid=%b ovr=%b",
                         $time, entry, word_out, word_valid, overrun, m_entry, m_wout, m_wv, m_ov);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // mask bit0=shift bit1=commit bit2=clear
    task automatic press(input logic [2:0] mask, input logic [3:0] nib, input bit ack_at_act,
                         input bit lat_chk, input logic [31:0] exp_before, input logic [31:0] exp_after);
        @(negedge clk);
        sw_nibble    = nib;
        key_shift_n  = ~mask[0];
        key_commit_n = ~mask[1];
        key_clear_n  = ~mask[2];
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == DB + 3) begin
                if (lat_chk) chk("latency_before", entry, exp_before);
                if (ack_at_act) word_ack = 1'b1;
            end
            if (i == DB + 4) begin
                word_ack = 1'b0;
                if (lat_chk) chk("latency_after", entry, exp_after);
            end
        end
        @(negedge clk);
        key_shift_n = 1'b1; key_commit_n = 1'b1; key_clear_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    int          hold [3];
    logic [31:0] exp_e;

    initial begin
        reset = 1'b1; sw_nibble = 4'h0; word_ack = 1'b0;
        key_shift_n = 1'b1; key_commit_n = 1'b1; key_clear_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_entry", entry, 32'h0);
        chk("reset_word_out", word_out, 32'h0);
        chk("reset_valid", {31'b0, word_valid}, 32'h0);
        chk("reset_overrun", {31'b0, overrun}, 32'h0);
        reset = 1'b0;

        // eight shifts, each landing exactly DB+3 clocks after first sample
        exp_e = 32'h0;
        for (int d = 1; d <= 8; d++) begin
            press(3'b001, 4'(d), 0, 1, exp_e, {exp_e[27:0], 4'(d)});
            exp_e = {exp_e[27:0], 4'(d)};
        end
        chk("entry_8_digits", entry, 32'h12345678);
        chk("model_entry_8_digits", m_entry, 32'h12345678);

        press(3'b001, 4'h9, 0, 1, 32'h12345678, 32'h23456789);
        press(3'b010, 4'h0, 0, 0, 0, 0);
        chk("commit_word", word_out, 32'h23456789);
        chk("commit_valid", {31'b0, word_valid}, 32'h1);
        chk("model_commit_word", m_wout, 32'h23456789);
        @(negedge clk); word_ack = 1'b1;
        @(negedge clk); word_ack = 1'b0;
        chk("ack_valid", {31'b0, word_valid}, 32'h0);
        chk("ack_word_hold", word_out, 32'h23456789);

        // bounce shorter than the qualification window
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); key_shift_n = 1'b0;
            @(negedge clk);
            @(negedge clk); key_shift_n = 1'b1;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        key_shift_n = 1'b0;
        repeat (3) @(negedge clk);
        key_shift_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_entry", entry, 32'h23456789);

        // overrun then clear
        press(3'b010, 4'h0, 0, 0, 0, 0);
        chk("commit2_word", word_out, 32'h23456789);
        chk("commit2_overrun", {31'b0, overrun}, 32'h0);
        press(3'b001, 4'hA, 0, 1, 32'h23456789, 32'h3456789A);
        press(3'b010, 4'h0, 0, 0, 0, 0);
        chk("overrun_word", word_out, 32'h3456789A);
        chk("overrun_flag", {31'b0, overrun}, 32'h1);
        press(3'b100, 4'h0, 0, 1, 32'h3456789A, 32'h0);
        chk("clear_overrun", {31'b0, overrun}, 32'h0);
        chk("clear_valid", {31'b0, word_valid}, 32'h1);

        // commit coincident with ack; shift coincident with clear
        press(3'b001, 4'hB, 0, 1, 32'h0, 32'h0000000B);
        press(3'b010, 4'h0, 1, 0, 0, 0);
        chk("commit_ack_valid", {31'b0, word_valid}, 32'h1);
        chk("commit_ack_overrun", {31'b0, overrun}, 32'h0);
        chk("commit_ack_word", word_out, 32'h0000000B);
        press(3'b101, 4'hC, 0, 1, 32'h0000000B, 32'h0);

        // reset mid-debounce with the key held through it
        @(negedge clk); sw_nibble = 4'h5; key_shift_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_entry", entry, 32'h0);
        chk("midreset_word", word_out, 32'h0);
        chk("midreset_valid", {31'b0, word_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        for (int i = 1; i <= DB + 4; i++) begin
            @(posedge clk); #1;
            if (i == DB + 3) chk("post_reset_before", entry, 32'h0);
            if (i == DB + 4) chk("post_reset_after", entry, 32'h5);
        end
        @(negedge clk); key_shift_n = 1'b1;
        repeat (10) @(negedge clk);

        // randomized phase
        for (int k = 0; k < 3; k++) hold[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    hold[k] = $urandom_range(1, 12);
                    case (k)
                        0: key_shift_n  = 1'($urandom_range(0, 1));
                        1: key_commit_n = 1'($urandom_range(0, 1));
                        default: key_clear_n = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    hold[k]--;
                end
            end
            sw_nibble = 4'($urandom);
            word_ack  = ($urandom_range(0, 5) == 0);
            reset     = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk); reset = 1'b0; word_ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
